inst_decoder_pipe: RTL and testbench
====================================

Name: inst_decoder_pipe

Overview:
- Parametrised successor decode stage. Registers one instruction per cycle from fetch into the ID/EX pipeline register.
- Extracts register addresses and sign-extends the immediate.
- Generates datapath control enables.
- Detects load-use hazards, inserts bubbles with upstream stall, supports flush, and counts inserted bubbles.

Parameters:
DATAPATH_WIDTH, 64, instruction and immediate output width
REGFILE_ADDR_WIDTH, 5, register address field width
INST_ADDR_WIDTH, 9, PC width
IMM_WIDTH, 16, immediate field width in inst_in[IMM_WIDTH-1:0]; must be ≤ DATAPATH_WIDTH-6-3*REGFILE_ADDR_WIDTH
CNT_WIDTH, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
in_valid  in  1  inst_in/pc_in valid
inst_in  in  DATAPATH_WIDTH  instruction
pc_in  in  INST_ADDR_WIDTH  PC of inst_in
ex_stall  in  1  downstream hold
flush  in  1  kill decode output (branch taken)
stall_out  out  1  upstream must hold inst_in/pc_in
valid_out  out  1  output register holds a real instruction
R1_addr_out  out  REGFILE_ADDR_WIDTH  source 1
R2_addr_out  out  REGFILE_ADDR_WIDTH  source 2
WR_addr_out  out  REGFILE_ADDR_WIDTH  destination
imm_out  out  DATAPATH_WIDTH  sign-extended immediate
pc_out  out  INST_ADDR_WIDTH  registered PC
WRegEn_out  out  1  register write enable
WMemEn_out  out  1  memory write enable
MemRd_out  out  1  load
ImmSel_out  out  1  ALU operand B = immediate
Branch_out  out  1  conditional branch
Jump_out  out  1  jump
illegal_out  out  1  sticky illegal-opcode flag
bubble_cnt  out  CNT_WIDTH  saturating count of hazard bubbles

Behaviour:
- Instruction field layout, with D = DATAPATH_WIDTH and A = REGFILE_ADDR_WIDTH:
  - opcode = inst_in[D-1:D-6]
  - WR = next A bits below opcode
  - R1 = next A bits below WR
  - R2 = next A bits below R1
  - imm = inst_in[IMM_WIDTH-1:0], sign-extended to D
- Opcode decode (W = WRegEn, M = WMemEn, R = MemRd, I = ImmSel, B = Branch, J = Jump; unlisted flags are 0):
  - 0x00 NOP: all 0
  - 0x01 ALU: W
  - 0x02 ALUI: W, I
  - 0x03 LOAD: W, R, I
  - 0x04 STORE: M, I
  - 0x05 BEQ: B
  - 0x06 JMP: J
  - Any other opcode: decoded as NOP, valid_out=1, and illegal_out set to 1 until reset.
- Source usage for the hazard check:
  - R1 is used by ALU, ALUI, LOAD, STORE and BEQ.
  - R2 is used by ALU, STORE and BEQ.
- Hazard (combinational) = valid_out & MemRd_out & (WR_addr_out != 0) & in_valid & ((R1 used & R1 == WR_addr_out) | (R2 used & R2 == WR_addr_out)).
- stall_out = ex_stall | (hazard & ~flush). It is combinational.
- Each clock edge applies exactly one case, in this priority order:
  1. reset == 0: valid_out, all control outputs, addresses, imm_out, pc_out, illegal_out and bubble_cnt all go to 0.
  2. flush: valid_out=0 and controls=0. Address, imm and pc outputs are don't-care. flush overrides ex_stall. The current input is discarded, not held.
  3. ex_stall: all output registers hold. No counting.
  4. hazard: bubble inserted; valid_out=0 and controls=0. bubble_cnt increments, saturating at all-ones. The input is held by upstream.
  5. in_valid: decoded fields, controls and pc register; valid_out=1.
  6. Otherwise: valid_out=0 and controls=0.
- Latency is 1 cycle from accept to output.
- Throughput is 1 instruction per cycle with no hazard. A load-use costs exactly 1 bubble: after the bubble the hazard term is 0, so the held instruction is accepted on the next edge.
- Register 0 never causes a hazard.
- Outputs with valid_out=0 must have every control enable 0.

Test Plan:
- Reset: drive reset=0 for 2 cycles with in_valid=1 and opcode 0x01 → all outputs 0 and bubble_cnt=0. Release reset → the following cycle shows valid_out=1, WRegEn_out=1.
- ALUI fields: ALUI with WR=3, R1=7, imm=16'hFFFE → after 1 cycle: WR_addr_out=3, R1_addr_out=7, imm_out=64'hFFFF_FFFF_FFFF_FFFE, ImmSel_out=1, WRegEn_out=1, pc_out=pc_in.
- Load-use: LOAD WR=5, then ALU R2=5 → stall_out=1 for 1 cycle, one bubble (valid_out=0), bubble_cnt=1, then ALU appears. Repeat with WR=0 → no stall.
- Flush during hazard: flush=1 together with ex_stall=1 or a hazard → next cycle valid_out=0, WMemEn_out=0, no bubble counted.
- Illegal opcode: opcode 0x3F → valid_out=1, all controls 0, illegal_out=1. It stays 1 across subsequent legal instructions until reset.
- Counter saturation: with CNT_WIDTH=2, force 5 load-use hazards → bubble_cnt sticks at 3.

Source files
------------

// File: rtl/inst_decoder_pipe_if.sv
// rtl/inst_decoder_pipe_if.sv - fetch-to-decode handshake and ID/EX output bundle
interface inst_decoder_pipe_if #(
  parameter int DATAPATH_WIDTH     = 64,
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int INST_ADDR_WIDTH    = 9,
  parameter int CNT_WIDTH          = 16
) ();
  logic                          in_valid;
  logic [DATAPATH_WIDTH-1:0]     inst_in;
  logic [INST_ADDR_WIDTH-1:0]    pc_in;
  logic                          ex_stall;
  logic                          flush;
  logic                          stall_out;
  logic                          valid_out;
  logic [REGFILE_ADDR_WIDTH-1:0] R1_addr_out;
  logic [REGFILE_ADDR_WIDTH-1:0] R2_addr_out;
  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out;
  logic [DATAPATH_WIDTH-1:0]     imm_out;
  logic [INST_ADDR_WIDTH-1:0]    pc_out;
  logic                          WRegEn_out;
  logic                          WMemEn_out;
  logic                          MemRd_out;
  logic                          ImmSel_out;
  logic                          Branch_out;
  logic                          Jump_out;
  logic                          illegal_out;
  logic [CNT_WIDTH-1:0]          bubble_cnt;

  modport master (
    output in_valid, inst_in, pc_in, ex_stall, flush,
    input  stall_out, valid_out, R1_addr_out, R2_addr_out, WR_addr_out, imm_out, pc_out,
           WRegEn_out, WMemEn_out, MemRd_out, ImmSel_out, Branch_out, Jump_out,
           illegal_out, bubble_cnt
  );

  modport slave (
    input  in_valid, inst_in, pc_in, ex_stall, flush,
    output stall_out, valid_out, R1_addr_out, R2_addr_out, WR_addr_out, imm_out, pc_out,
           WRegEn_out, WMemEn_out, MemRd_out, ImmSel_out, Branch_out, Jump_out,
           illegal_out, bubble_cnt
  );
endinterface

// File: rtl/inst_decoder_pipe.sv
// rtl/inst_decoder_pipe.sv - decode stage with load-use bubble insertion, flush and bubble counter
module inst_decoder_pipe #(
  parameter int DATAPATH_WIDTH     = 64,
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int INST_ADDR_WIDTH    = 9,
  parameter int IMM_WIDTH          = 16,
  parameter int CNT_WIDTH          = 16
) (
  input  logic               clk,
  input  logic               reset,
  inst_decoder_pipe_if.slave bus
);
  localparam int D = DATAPATH_WIDTH;
  localparam int A = REGFILE_ADDR_WIDTH;

  logic [5:0]   opcode;
  logic [A-1:0] f_wr, f_r1, f_r2;
  logic [D-1:0] f_imm;
  logic         unused_inst_bits;

  assign opcode = bus.inst_in[D-1 -: 6];
  assign f_wr   = bus.inst_in[D-7 -: A];
  assign f_r1   = bus.inst_in[D-7-A -: A];
  assign f_r2   = bus.inst_in[D-7-2*A -: A];
  assign f_imm  = {{(D-IMM_WIDTH){bus.inst_in[IMM_WIDTH-1]}}, bus.inst_in[IMM_WIDTH-1:0]};
  assign unused_inst_bits = ^bus.inst_in;

  // ctrl bit order: {WRegEn, WMemEn, MemRd, ImmSel, Branch, Jump}
  logic [5:0] d_ctrl;
  logic       d_use_r1, d_use_r2, d_illegal;

  always_comb begin
    d_ctrl    = 6'b000000;
    d_use_r1  = 1'b0;
    d_use_r2  = 1'b0;
    d_illegal = 1'b0;
    case (opcode)
      6'h00: ;
      6'h01: begin d_ctrl = 6'b100000; d_use_r1 = 1'b1; d_use_r2 = 1'b1; end
      6'h02: begin d_ctrl = 6'b100100; d_use_r1 = 1'b1; end
      6'h03: begin d_ctrl = 6'b101100; d_use_r1 = 1'b1; end
      6'h04: begin d_ctrl = 6'b010100; d_use_r1 = 1'b1; d_use_r2 = 1'b1; end
      6'h05: begin d_ctrl = 6'b000010; d_use_r1 = 1'b1; d_use_r2 = 1'b1; end
      6'h06: begin d_ctrl = 6'b000001; end
      default: d_illegal = 1'b1;
    endcase
  end

  logic                       valid_q;
  logic [5:0]                 ctrl_q;
  logic [A-1:0]               wr_q, r1_q, r2_q;
  logic [D-1:0]               imm_q;
  logic [INST_ADDR_WIDTH-1:0] pc_q;
  logic                       illegal_q;
  logic [CNT_WIDTH-1:0]       cnt_q;
  logic                       hazard;

  // Only a load still in the output register can create a use hazard; r0 is hardwired zero.
  assign hazard = valid_q & ctrl_q[3] & (wr_q != '0) & bus.in_valid &
                  ((d_use_r1 & (f_r1 == wr_q)) | (d_use_r2 & (f_r2 == wr_q)));
  assign bus.stall_out = bus.ex_stall | (hazard & ~bus.flush);

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      wr_q      <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (bus.ex_stall) begin
      valid_q <= valid_q;
    end else if (hazard) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      if (~&cnt_q) cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else if (bus.in_valid) begin
      valid_q   <= 1'b1;
      ctrl_q    <= d_ctrl;
      wr_q      <= f_wr;
      r1_q      <= f_r1;
      r2_q      <= f_r2;
      imm_q     <= f_imm;
      pc_q      <= bus.pc_in;
      illegal_q <= illegal_q | d_illegal;
    end else begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end
  end

  assign bus.valid_out   = valid_q;
  assign bus.WRegEn_out  = ctrl_q[5];
  assign bus.WMemEn_out  = ctrl_q[4];
  assign bus.MemRd_out   = ctrl_q[3];
  assign bus.ImmSel_out  = ctrl_q[2];
  assign bus.Branch_out  = ctrl_q[1];
  assign bus.Jump_out    = ctrl_q[0];
  assign bus.WR_addr_out = wr_q;
  assign bus.R1_addr_out = r1_q;
  assign bus.R2_addr_out = r2_q;
  assign bus.imm_out     = imm_q;
  assign bus.pc_out      = pc_q;
  assign bus.illegal_out = illegal_q;
  assign bus.bubble_cnt  = cnt_q;
endmodule

// File: tb/tb_inst_decoder_pipe.sv
// tb/tb_inst_decoder_pipe.sv - randomized and directed bench for inst_decoder_pipe against a reference model
module tb_inst_decoder_pipe;
  localparam int CW = 2;

  logic clk;
  logic reset;

  inst_decoder_pipe_if #(.DATAPATH_WIDTH(64), .REGFILE_ADDR_WIDTH(5), .INST_ADDR_WIDTH(9),
                         .CNT_WIDTH(CW)) bus ();

  inst_decoder_pipe #(.DATAPATH_WIDTH(64), .REGFILE_ADDR_WIDTH(5), .INST_ADDR_WIDTH(9),
                      .IMM_WIDTH(16), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference state: what the ID/EX register should hold
  logic        m_valid, m_ill, m_rst_seen;
  logic [5:0]  m_ctrl;
  logic [4:0]  m_wr, m_r1, m_r2;
  logic [63:0] m_imm;
  logic [8:0]  m_pc;
  int          m_cnt;
  logic        m_stall;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // per opcode: {W,M,R,I,B,J}, R1 used, R2 used, illegal
  function automatic logic [8:0] spec_decode(input logic [5:0] op);
    case (op)
      6'd0: return {6'b000000, 1'b0, 1'b0, 1'b0};
      6'd1: return {6'b100000, 1'b1, 1'b1, 1'b0};
      6'd2: return {6'b100100, 1'b1, 1'b0, 1'b0};
      6'd3: return {6'b101100, 1'b1, 1'b0, 1'b0};
      6'd4: return {6'b010100, 1'b1, 1'b1, 1'b0};
      6'd5: return {6'b000010, 1'b1, 1'b1, 1'b0};
      6'd6: return {6'b000001, 1'b0, 1'b0, 1'b0};
      default: return {6'b000000, 1'b0, 1'b0, 1'b1};
    endcase
  endfunction

  function automatic logic [63:0] mk(input logic [5:0] op, input logic [4:0] wr, input logic [4:0] r1,
                                     input logic [4:0] r2, input logic [15:0] imm);
    return {op, wr, r1, r2, 27'($urandom), imm};
  endfunction

  function automatic logic model_hazard(input logic iv, input logic [63:0] inst);
    logic [8:0] d;
    logic [4:0] r1, r2;
    d  = spec_decode(inst[63:58]);
    r1 = inst[52:48];
    r2 = inst[47:43];
    return m_valid && m_ctrl[3] && (m_wr != 5'd0) && iv &&
           ((d[2] && r1 == m_wr) || (d[1] && r2 == m_wr));
  endfunction

  task automatic step(input logic rst_n, input logic iv, input logic [63:0] inst, input logic [8:0] pc,
                      input logic exs, input logic fl);
    logic       hz;
    logic [8:0] d;
    reset        = rst_n;
    bus.in_valid = iv;
    bus.inst_in  = inst;
    bus.pc_in    = pc;
    bus.ex_stall = exs;
    bus.flush    = fl;
    #2;
    hz      = model_hazard(iv, inst);
    m_stall = exs | (hz & ~fl);
    if (rst_n) check("stall_out", {63'd0, bus.stall_out}, {63'd0, m_stall});
    d = spec_decode(inst[63:58]);
    if (!rst_n) begin
      m_valid = 0; m_ctrl = 0; m_wr = 0; m_r1 = 0; m_r2 = 0; m_imm = 0; m_pc = 0;
      m_ill = 0; m_cnt = 0;
    end else if (fl) begin
      m_valid = 0; m_ctrl = 0;
    end else if (exs) begin
      m_valid = m_valid;
    end else if (hz) begin
      m_valid = 0; m_ctrl = 0;
      m_cnt = (m_cnt == (1 << CW) - 1) ? m_cnt : m_cnt + 1;
    end else if (iv) begin
      m_valid = 1; m_ctrl = d[8:3];
      m_wr = inst[57:53]; m_r1 = inst[52:48]; m_r2 = inst[47:43];
      m_imm = {{48{inst[15]}}, inst[15:0]};
      m_pc = pc;
      m_ill = m_ill | d[0];
    end else begin
      m_valid = 0; m_ctrl = 0;
    end
    m_rst_seen = !rst_n;
    @(posedge clk);
    #1;
    check("valid_out", {63'd0, bus.valid_out}, {63'd0, m_valid});
    check("ctrl", {58'd0, bus.WRegEn_out, bus.WMemEn_out, bus.MemRd_out, bus.ImmSel_out,
                   bus.Branch_out, bus.Jump_out}, {58'd0, m_ctrl});
    check("illegal_out", {63'd0, bus.illegal_out}, {63'd0, m_ill});
    check("bubble_cnt", {62'd0, bus.bubble_cnt}, 64'(m_cnt));
    if (m_valid || m_rst_seen) begin
      check("WR_addr_out", {59'd0, bus.WR_addr_out}, {59'd0, m_wr});
      check("R1_addr_out", {59'd0, bus.R1_addr_out}, {59'd0, m_r1});
      check("R2_addr_out", {59'd0, bus.R2_addr_out}, {59'd0, m_r2});
      check("imm_out", bus.imm_out, m_imm);
      check("pc_out", {55'd0, bus.pc_out}, {55'd0, m_pc});
    end
  endtask

  logic [63:0] h_inst;
  logic [8:0]  h_pc;
  logic        h_iv;
  logic [5:0]  r_op;

  initial begin
    m_valid = 0; m_ill = 0; m_ctrl = 0; m_cnt = 0; m_stall = 0;
    bus.in_valid = 0; bus.inst_in = 0; bus.pc_in = 0; bus.ex_stall = 0; bus.flush = 0;
    reset = 0;
    @(posedge clk); #1;

    // reset with a live ALU on the input, then release
    step(0, 1, mk(6'h01, 5'd1, 5'd2, 5'd3, 16'h0010), 9'h010, 0, 0);
    step(0, 1, mk(6'h01, 5'd1, 5'd2, 5'd3, 16'h0010), 9'h010, 0, 0);
    step(1, 1, mk(6'h01, 5'd1, 5'd2, 5'd3, 16'h0010), 9'h010, 0, 0);
    check("release_valid_wregen", {62'd0, bus.valid_out, bus.WRegEn_out}, 64'd3);

    // ALUI field extraction and sign extension
    step(1, 1, mk(6'h02, 5'd3, 5'd7, 5'd0, 16'hFFFE), 9'h1A5, 0, 0);
    check("alui_imm", bus.imm_out, 64'hFFFF_FFFF_FFFF_FFFE);
    check("alui_pc", {55'd0, bus.pc_out}, 64'h1A5);

    // load-use on R2: exactly one bubble
    step(1, 1, mk(6'h03, 5'd5, 5'd1, 5'd0, 16'h0004), 9'h020, 0, 0);
    step(1, 1, mk(6'h01, 5'd2, 5'd1, 5'd5, 16'h0000), 9'h021, 0, 0);
    check("loaduse_bubble", {62'd0, bus.valid_out, bus.bubble_cnt == 2'd1}, 64'd1);
    step(1, 1, mk(6'h01, 5'd2, 5'd1, 5'd5, 16'h0000), 9'h021, 0, 0);
    check("loaduse_after", {63'd0, bus.stall_out}, 64'd0);

    // destination r0 never stalls
    step(1, 1, mk(6'h03, 5'd0, 5'd1, 5'd0, 16'h0004), 9'h030, 0, 0);
    step(1, 1, mk(6'h01, 5'd2, 5'd0, 5'd0, 16'h0000), 9'h031, 0, 0);

    // flush beats a hazard and an ex_stall; no bubble counted
    step(1, 1, mk(6'h03, 5'd6, 5'd1, 5'd0, 16'h0004), 9'h040, 0, 0);
    step(1, 1, mk(6'h01, 5'd2, 5'd6, 5'd0, 16'h0000), 9'h041, 0, 1);
    step(1, 1, mk(6'h04, 5'd0, 5'd1, 5'd2, 16'h0008), 9'h042, 0, 0);
    step(1, 1, mk(6'h04, 5'd0, 5'd1, 5'd2, 16'h0008), 9'h043, 1, 1);
    check("flush_wmem", {62'd0, bus.valid_out, bus.WMemEn_out}, 64'd0);
    step(1, 0, 64'd0, 9'h000, 0, 0);

    // illegal opcode is sticky
    step(1, 1, mk(6'h3F, 5'd1, 5'd2, 5'd3, 16'h1234), 9'h050, 0, 0);
    step(1, 1, mk(6'h01, 5'd1, 5'd2, 5'd3, 16'h1234), 9'h051, 0, 0);
    check("illegal_sticky", {63'd0, bus.illegal_out}, 64'd1);

    // five more load-use bubbles saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      step(1, 1, mk(6'h03, 5'd2, 5'd1, 5'd0, 16'h0000), 9'(i), 0, 0);
      step(1, 1, mk(6'h02, 5'd4, 5'd2, 5'd0, 16'h0001), 9'(i + 1), 0, 0);
      step(1, 1, mk(6'h02, 5'd4, 5'd2, 5'd0, 16'h0001), 9'(i + 1), 0, 0);
    end
    check("cnt_saturated", {62'd0, bus.bubble_cnt}, 64'd3);

    // randomized traffic; upstream holds its input whenever stall_out was asserted
    step(0, 0, 64'd0, 9'd0, 0, 0);
    h_iv = 0; h_inst = 0; h_pc = 0;
    for (int i = 0; i < 400; i++) begin
      if (!m_stall) begin
        r_op   = ($urandom_range(0, 15) == 0) ? 6'(32 + $urandom_range(0, 31)) : 6'($urandom_range(0, 6));
        h_iv   = ($urandom_range(0, 7) != 0);
        h_inst = mk(r_op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 16'($urandom));
        h_pc   = 9'($urandom);
      end
      step(($urandom_range(0, 199) != 0), h_iv, h_inst, h_pc,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0));
    end

    // reset clears sticky state
    step(0, 1, mk(6'h01, 5'd1, 5'd2, 5'd3, 16'h0000), 9'd0, 0, 0);
    check("reset_clears", {61'd0, bus.illegal_out, bus.bubble_cnt}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
